mem_arb_sched: RTL and testbench
================================

# mem_arb_sched

Sequential memory arbiter and transaction scheduler between the L1 instruction cache, the L1 data cache and the single-ported main memory model. Accepts one block request at a time from either cache, holds it stable until main memory accepts it, tracks the single outstanding transaction, and routes the response back to the originating cache through a registered response stage. Priority goes to the instruction cache; an optional starvation guard bounds how long a pending data-cache request can be bypassed.

## Interface
- STARVE_LIMIT, default 4: consecutive icache grants allowed while a dcache request is pending (1..15; used only with the guard compiled in).

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- icache_req_valid  in  1  icache block read request.
- icache_req_block_addr  in  main_mem_block_addr_t  icache block address.
- icache_req_ready  out  1  icache request accepted this cycle.
- dcache_req_valid  in  1  dcache request.
- dcache_req_type  in  req_type_t  READ or WRITE.
- dcache_req_block_addr  in  main_mem_block_addr_t  dcache block address.
- dcache_req_block_data  in  block_data_t  write data.
- dcache_req_ready  out  1  dcache request accepted this cycle.
- mem_req_valid  out  1  request to main memory.
- mem_req_ready  in  1  main memory accepts the request.
- mem_req_cache_type  out  cache_type_t  ICACHE or DCACHE.
- mem_req_type  out  req_type_t  READ or WRITE.
- mem_req_block_addr  out  main_mem_block_addr_t  latched address.
- mem_req_block_data  out  block_data_t  latched write data (0 for reads).
- mem_resp_valid  in  1  response from main memory (reads and write acks).
- mem_resp_cache_type  in  cache_type_t  response owner.
- mem_resp_block_data  in  block_data_t  read data.
- icache_resp_valid  out  1  one-cycle response pulse to icache.
- icache_resp_block_data  out  block_data_t  read data.
- dcache_resp_valid  out  1  one-cycle response/write-ack pulse to dcache.
- dcache_resp_block_data  out  block_data_t  read data (0 for write acks).
- arb_busy  out  1  state != IDLE.
- arb_err  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: grant computed combinationally; exactly one of icache_req_ready/dcache_req_ready asserted when that cache is granted, never both. Default grant: icache if valid, else dcache. On handshake, latch cache type, req type, address, data (data forced to 0 for icache and dcache READ); go to ISSUE.
- ISSUE: mem_req_valid=1; mem_req_* driven from latched registers, stable until mem_req_valid && mem_req_ready; then go to WAIT. Both cache readies 0.
- WAIT: both cache readies 0. mem_resp_valid with mem_resp_cache_type equal to latched type: register response into owner's resp outputs, go to IDLE. Mismatched type: ignored, arb_err set, remain WAIT.
- mem_resp_valid in IDLE or ISSUE: ignored, arb_err set.
- Response outputs of the non-owner and all resp data when not valid are 0.
- arb_err cleared only by rst.

## Timing
- Reset: state IDLE; all *_valid, *_ready driven from state, all resp data, mem_req_* fields, arb_busy, arb_err, starvation counter = 0. Reset mid-transaction drops the transaction; no response delivered.
- Cache handshake in cycle N -> mem_req_valid high from N+1.
- mem_req_ready in ISSUE at cycle M -> WAIT at M+1; mem_resp_valid accepted earliest at M+1.
- Matching mem_resp_valid at cycle R -> *_resp_valid pulse in R+1 (exactly one cycle); state IDLE in R+1, new grant possible in R+1.
- Minimum request-to-request spacing: 3 cycles (IDLE, ISSUE, WAIT with zero-wait memory).
- Simultaneous icache and dcache valid in IDLE: single grant per rules above; loser holds valid and is granted in a later IDLE.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: 4-bit counter increments on each icache grant made while dcache_req_valid is high; clears on dcache grant or on icache grant with dcache_req_valid low. When counter == STARVE_LIMIT and both valid, dcache is granted instead; counter clears.
- Not defined: strict icache priority; no counter; STARVE_LIMIT unused.

## Test plan
- Icache read addr 0x40, mem_req_ready same cycle as ISSUE, resp 2 cycles later with data 0xA5.. -> icache_resp_valid one-cycle pulse with 0xA5.., dcache_resp_valid 0, arb_busy low after.
- Dcache WRITE addr 0x80 data 0x1234.., mem_req_ready held low 5 cycles -> mem_req_* stable all 5 cycles, write ack -> dcache_resp_valid pulse, data 0.
- Both valid continuously, guard enabled, STARVE_LIMIT=4 -> grant sequence I,I,I,I,D,I,I,I,I,D; guard disabled -> all I.
- Response with DCACHE type while WAIT for ICACHE -> ignored, arb_err=1, state stays WAIT; correct response then completes normally.
- rst asserted in WAIT -> next cycle IDLE, all outputs 0, later response not forwarded (arb_err set).
- mem_resp_valid in IDLE -> no resp pulse, arb_err=1 until rst.

Source files
------------

// File: rtl/mem_arb_sched.sv
// ---------------------------------------------------------------------------
// mem_arb_sched
//
// Purpose:
//   Arbitrates between the L1 instruction cache and the L1 data cache for the
//   single-ported main memory model. One block transaction is in flight at a
//   time. The winning request is captured, presented to memory unchanged until
//   memory accepts it, and the matching response is returned to the cache that
//   asked for it through a registered response stage. The instruction cache
//   has priority.
//
// Optional feature (compile-time macro):
//   MEM_ARB_STARVE_GUARD_EN - when defined, a 4-bit counter tracks how many
//   icache grants in a row were made while a dcache request was waiting. Once
//   it reaches STARVE_LIMIT, the dcache wins the next contested grant. When the
//   macro is not defined, icache priority is strict and STARVE_LIMIT is unused.
//
// Parameters:
//   ADDR_W        block address width
//   DATA_W        block data width
//   STARVE_LIMIT  contested icache grants allowed before dcache is forced (1..15)
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   icache_req_valid/_block_addr     icache block read request
//   icache_req_ready                 icache request accepted this cycle
//   dcache_req_valid/_type/_block_addr/_block_data
//                                    dcache read or write request
//   dcache_req_ready                 dcache request accepted this cycle
//   mem_req_valid/_ready             request handshake towards main memory
//   mem_req_cache_type/_type/_block_addr/_block_data
//                                    latched request fields (data 0 for reads)
//   mem_resp_valid/_cache_type/_block_data
//                                    response from main memory
//   icache_resp_valid/_block_data    one-cycle response pulse to icache
//   dcache_resp_valid/_block_data    one-cycle response/write-ack pulse to dcache
//   arb_busy                         a transaction is being issued or awaited
//   arb_err                          sticky protocol error (cleared by rst only)
//
// Encodings: req type READ=0 WRITE=1, cache type ICACHE=0 DCACHE=1.
// ---------------------------------------------------------------------------
module mem_arb_sched #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req_valid,
    input  logic [ADDR_W-1:0] icache_req_block_addr,
    output logic              icache_req_ready,
    input  logic              dcache_req_valid,
    input  logic              dcache_req_type,
    input  logic [ADDR_W-1:0] dcache_req_block_addr,
    input  logic [DATA_W-1:0] dcache_req_block_data,
    output logic              dcache_req_ready,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_cache_type,
    output logic              mem_req_type,
    output logic [ADDR_W-1:0] mem_req_block_addr,
    output logic [DATA_W-1:0] mem_req_block_data,
    input  logic              mem_resp_valid,
    input  logic              mem_resp_cache_type,
    input  logic [DATA_W-1:0] mem_resp_block_data,
    output logic              icache_resp_valid,
    output logic [DATA_W-1:0] icache_resp_block_data,
    output logic              dcache_resp_valid,
    output logic [DATA_W-1:0] dcache_resp_block_data,
    output logic              arb_busy,
    output logic              arb_err
);

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;
    localparam logic CACHE_I   = 1'b0;
    localparam logic CACHE_D   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Latched transaction fields, held until the next grant overwrites them.
    logic              r_cacheType;
    logic              r_reqType;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    // Registered response stage.
    logic              r_iRespValid;
    logic [DATA_W-1:0] r_iRespData;
    logic              r_dRespValid;
    logic [DATA_W-1:0] r_dRespData;
    logic              r_err;

    logic w_grantI;
    logic w_grantD;
    logic w_starve;
    logic w_respMatch;
    logic w_respBad;

    // A response only counts when we are actually waiting and it belongs to
    // the cache that owns the outstanding transaction. Anything else is a
    // protocol violation by the memory side and only raises the error flag.
    assign w_respMatch = (r_state == WAIT) && mem_resp_valid &&
                         (mem_resp_cache_type == r_cacheType);
    assign w_respBad   = mem_resp_valid && !w_respMatch;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starveCnt;

    // Forcing the dcache only matters when both caches are competing; a lone
    // icache request is always served.
    assign w_starve = (r_starveCnt == LIMIT) && icache_req_valid && dcache_req_valid;

    // The counter measures how long the dcache has been bypassed. Any dcache
    // grant, or an icache grant with no dcache waiting, ends the streak.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starveCnt <= 4'd0;
        end else if (w_grantD) begin
            r_starveCnt <= 4'd0;
        end else if (w_grantI) begin
            if (dcache_req_valid && (r_starveCnt != 4'hF)) begin
                r_starveCnt <= r_starveCnt + 4'd1;
            end else if (!dcache_req_valid) begin
                r_starveCnt <= 4'd0;
            end
        end
    end
`else
    logic [3:0] w_unusedLimit;

    assign w_starve      = 1'b0;
    assign w_unusedLimit = 4'(STARVE_LIMIT);
`endif

    // Grant decision, only meaningful in IDLE. Ready is raised for exactly one
    // requester, and only if that requester is valid, so grant == handshake.
    always_comb begin
        w_grantI = 1'b0;
        w_grantD = 1'b0;
        if (r_state == IDLE) begin
            if (icache_req_valid && !w_starve) begin
                w_grantI = 1'b1;
            end else if (dcache_req_valid) begin
                w_grantD = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and state-derived outputs.
    always_comb begin
        w_nextState      = r_state;
        icache_req_ready = 1'b0;
        dcache_req_ready = 1'b0;
        mem_req_valid    = 1'b0;
        arb_busy         = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                icache_req_ready = w_grantI;
                dcache_req_ready = w_grantD;
                if (w_grantI || w_grantD) begin
                    w_nextState = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (w_respMatch) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Request capture, response registration and the sticky error flag.
    // Read requests never carry data towards memory, and write acks never
    // carry data back to the dcache, so both are forced to zero here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cacheType  <= CACHE_I;
            r_reqType    <= REQ_READ;
            r_addr       <= '0;
            r_data       <= '0;
            r_iRespValid <= 1'b0;
            r_iRespData  <= '0;
            r_dRespValid <= 1'b0;
            r_dRespData  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_iRespValid <= 1'b0;
            r_iRespData  <= '0;
            r_dRespValid <= 1'b0;
            r_dRespData  <= '0;

            if (w_grantI) begin
                r_cacheType <= CACHE_I;
                r_reqType   <= REQ_READ;
                r_addr      <= icache_req_block_addr;
                r_data      <= '0;
            end else if (w_grantD) begin
                r_cacheType <= CACHE_D;
                r_reqType   <= dcache_req_type;
                r_addr      <= dcache_req_block_addr;
                r_data      <= (dcache_req_type == REQ_WRITE) ? dcache_req_block_data : '0;
            end

            if (w_respMatch) begin
                if (r_cacheType == CACHE_I) begin
                    r_iRespValid <= 1'b1;
                    r_iRespData  <= mem_resp_block_data;
                end else begin
                    r_dRespValid <= 1'b1;
                    r_dRespData  <= (r_reqType == REQ_WRITE) ? '0 : mem_resp_block_data;
                end
            end

            if (w_respBad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_req_cache_type     = r_cacheType;
    assign mem_req_type           = r_reqType;
    assign mem_req_block_addr     = r_addr;
    assign mem_req_block_data     = r_data;
    assign icache_resp_valid      = r_iRespValid;
    assign icache_resp_block_data = r_iRespData;
    assign dcache_resp_valid      = r_dRespValid;
    assign dcache_resp_block_data = r_dRespData;
    assign arb_err                = r_err;

endmodule

// File: tb/tb_mem_arb_sched.sv
// ---------------------------------------------------------------------------
// tb_mem_arb_sched
//
// Self-checking bench for mem_arb_sched. A transaction-level model of the
// arbiter (one outstanding request, whether memory has taken it, the pending
// response pulse, the error flag and the bypass count) predicts every output
// on each falling edge. Directed scenarios add literal expectations, then a
// randomized phase drives both caches and a misbehaving memory.
// Honours MEM_ARB_STARVE_GUARD_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mem_arb_sched;

    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          icache_req_valid = 1'b0;
    logic [AW-1:0] icache_req_block_addr = '0;
    logic          icache_req_ready;
    logic          dcache_req_valid = 1'b0;
    logic          dcache_req_type = 1'b0;
    logic [AW-1:0] dcache_req_block_addr = '0;
    logic [DW-1:0] dcache_req_block_data = '0;
    logic          dcache_req_ready;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic          mem_req_cache_type;
    logic          mem_req_type;
    logic [AW-1:0] mem_req_block_addr;
    logic [DW-1:0] mem_req_block_data;
    logic          mem_resp_valid = 1'b0;
    logic          mem_resp_cache_type = 1'b0;
    logic [DW-1:0] mem_resp_block_data = '0;
    logic          icache_resp_valid;
    logic [DW-1:0] icache_resp_block_data;
    logic          dcache_resp_valid;
    logic [DW-1:0] dcache_resp_block_data;
    logic          arb_busy;
    logic          arb_err;

    always #5 clk = ~clk;

    mem_arb_sched #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .icache_req_valid(icache_req_valid),
        .icache_req_block_addr(icache_req_block_addr),
        .icache_req_ready(icache_req_ready),
        .dcache_req_valid(dcache_req_valid),
        .dcache_req_type(dcache_req_type),
        .dcache_req_block_addr(dcache_req_block_addr),
        .dcache_req_block_data(dcache_req_block_data),
        .dcache_req_ready(dcache_req_ready),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_cache_type(mem_req_cache_type),
        .mem_req_type(mem_req_type),
        .mem_req_block_addr(mem_req_block_addr),
        .mem_req_block_data(mem_req_block_data),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_cache_type(mem_resp_cache_type),
        .mem_resp_block_data(mem_resp_block_data),
        .icache_resp_valid(icache_resp_valid),
        .icache_resp_block_data(icache_resp_block_data),
        .dcache_resp_valid(dcache_resp_valid),
        .dcache_resp_block_data(dcache_resp_block_data),
        .arb_busy(arb_busy),
        .arb_err(arb_err)
    );

    int compared   = 0;
    int mismatched = 0;

    // Transaction-level model state.
    bit            mBusy   = 1'b0;
    bit            mIssued = 1'b0;
    bit            mCache  = 1'b0;
    bit            mType   = 1'b0;
    logic [AW-1:0] mAddr   = '0;
    logic [DW-1:0] mData   = '0;
    bit            mIValid = 1'b0;
    bit            mDValid = 1'b0;
    logic [DW-1:0] mIData  = '0;
    logic [DW-1:0] mDData  = '0;
    bit            mErr    = 1'b0;
    int            mCnt    = 0;

    // Handshakes seen on the DUT during the priority scenario (1 = dcache).
    bit            logEnable  = 1'b0;
    logic [9:0]    grantLog   = '0;
    int            grantCount = 0;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Who should win right now: 0 none, 1 icache, 2 dcache.
    function automatic int modelGrant();
        if (mBusy) return 0;
        if (icache_req_valid && dcache_req_valid) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (mCnt == LIM) return 2;
`endif
            return 1;
        end
        if (icache_req_valid) return 1;
        if (dcache_req_valid) return 2;
        return 0;
    endfunction

    // Compare every output against the model, then advance the model with the
    // inputs that the next rising edge will sample.
    always @(negedge clk) begin
        int g;
        g = modelGrant();
        checkOutput("icache_req_ready", icache_req_ready, (g == 1));
        checkOutput("dcache_req_ready", dcache_req_ready, (g == 2));
        checkOutput("mem_req_valid", mem_req_valid, (mBusy && !mIssued));
        checkOutput("mem_req_cache_type", mem_req_cache_type, mCache);
        checkOutput("mem_req_type", mem_req_type, mType);
        checkOutput("mem_req_block_addr", mem_req_block_addr, mAddr);
        checkOutput("mem_req_block_data", mem_req_block_data, mData);
        checkOutput("icache_resp_valid", icache_resp_valid, mIValid);
        checkOutput("icache_resp_block_data", icache_resp_block_data, mIData);
        checkOutput("dcache_resp_valid", dcache_resp_valid, mDValid);
        checkOutput("dcache_resp_block_data", dcache_resp_block_data, mDData);
        checkOutput("arb_busy", arb_busy, mBusy);
        checkOutput("arb_err", arb_err, mErr);

        if (!rst && logEnable && grantCount < 10) begin
            if (icache_req_valid && icache_req_ready) begin
                grantLog[grantCount] = 1'b0;
                grantCount++;
            end else if (dcache_req_valid && dcache_req_ready) begin
                grantLog[grantCount] = 1'b1;
                grantCount++;
            end
        end

        if (rst) begin
            mBusy = 0; mIssued = 0; mCache = 0; mType = 0; mAddr = '0; mData = '0;
            mIValid = 0; mDValid = 0; mIData = '0; mDData = '0; mErr = 0; mCnt = 0;
        end else begin
            mIValid = 0; mDValid = 0; mIData = '0; mDData = '0;
            if (mem_resp_valid) begin
                if (mBusy && mIssued && (mem_resp_cache_type == mCache)) begin
                    mBusy = 0;
                    if (!mCache) begin
                        mIValid = 1;
                        mIData  = mem_resp_block_data;
                    end else begin
                        mDValid = 1;
                        mDData  = mType ? '0 : mem_resp_block_data;
                    end
                end else begin
                    mErr = 1;
                end
            end
            if (g == 1) begin
                mBusy = 1; mIssued = 0; mCache = 0; mType = 0;
                mAddr = icache_req_block_addr; mData = '0;
                mCnt  = dcache_req_valid ? mCnt + 1 : 0;
            end else if (g == 2) begin
                mBusy = 1; mIssued = 0; mCache = 1; mType = dcache_req_type;
                mAddr = dcache_req_block_addr;
                mData = dcache_req_type ? dcache_req_block_data : '0;
                mCnt  = 0;
            end else if (mBusy && !mIssued && mem_req_ready) begin
                mIssued = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit iv, input logic [AW-1:0] ia,
                                 input bit dv, input bit dt, input logic [AW-1:0] da,
                                 input logic [DW-1:0] dd, input bit mrdy,
                                 input bit rv, input bit rt, input logic [DW-1:0] rd);
        icache_req_valid      = iv;
        icache_req_block_addr = ia;
        dcache_req_valid      = dv;
        dcache_req_type       = dt;
        dcache_req_block_addr = da;
        dcache_req_block_data = dd;
        mem_req_ready         = mrdy;
        mem_resp_valid        = rv;
        mem_resp_cache_type   = rt;
        mem_resp_block_data   = rd;
    endtask

    task automatic quiet();
        applyStimulus(0, '0, 0, 0, '0, '0, 0, 0, 0, '0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        quiet();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [9:0] expSeq;
`ifdef MEM_ARB_STARVE_GUARD_EN
        expSeq = 10'b10_0001_0000;
`else
        expSeq = 10'b00_0000_0000;
`endif

        // Reset state.
        quiet();
        tick();
        tick();
        checkOutput("reset_busy", arb_busy, 0);
        checkOutput("reset_err", arb_err, 0);
        checkOutput("reset_memValid", mem_req_valid, 0);
        checkOutput("reset_memAddr", mem_req_block_addr, 0);
        checkOutput("reset_iResp", icache_resp_valid, 0);
        rst = 1'b0;

        // Icache read of block 0x40, memory ready in the first ISSUE cycle,
        // response two cycles after that.
        applyStimulus(1, 32'h40, 0, 0, '0, '0, 0, 0, 0, '0);
        #1;
        checkOutput("t1_iReady", icache_req_ready, 1);
        checkOutput("t1_dReady", dcache_req_ready, 0);
        tick();
        applyStimulus(0, '0, 0, 0, '0, '0, 1, 0, 0, '0);
        #1;
        checkOutput("t1_memValid", mem_req_valid, 1);
        checkOutput("t1_memAddr", mem_req_block_addr, 64'h40);
        checkOutput("t1_memCache", mem_req_cache_type, 0);
        checkOutput("t1_memData", mem_req_block_data, 0);
        tick();
        quiet();
        #1;
        checkOutput("t1_waitBusy", arb_busy, 1);
        checkOutput("t1_waitMemValid", mem_req_valid, 0);
        tick();
        applyStimulus(0, '0, 0, 0, '0, '0, 0, 1, 0, 64'hA5A5_A5A5_A5A5_A5A5);
        tick();
        quiet();
        #1;
        checkOutput("t1_iRespValid", icache_resp_valid, 1);
        checkOutput("t1_iRespData", icache_resp_block_data, 64'hA5A5_A5A5_A5A5_A5A5);
        checkOutput("t1_dRespValid", dcache_resp_valid, 0);
        checkOutput("t1_idleBusy", arb_busy, 0);
        tick();
        checkOutput("t1_iRespPulseEnd", icache_resp_valid, 0);
        checkOutput("t1_iRespDataClear", icache_resp_block_data, 0);

        // Dcache write to block 0x80 with memory stalling for five cycles.
        applyStimulus(0, '0, 1, 1, 32'h80, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, '0);
        #1;
        checkOutput("t2_dReady", dcache_req_ready, 1);
        checkOutput("t2_iReady", icache_req_ready, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            applyStimulus(0, '0, 0, 0, 32'hFFF, 64'hBAD, 0, 0, 0, '0);
            #1;
            checkOutput("t2_stallValid", mem_req_valid, 1);
            checkOutput("t2_stallAddr", mem_req_block_addr, 64'h80);
            checkOutput("t2_stallData", mem_req_block_data, 64'h1234_5678_9ABC_DEF0);
            checkOutput("t2_stallType", mem_req_type, 1);
            checkOutput("t2_stallCache", mem_req_cache_type, 1);
        end
        tick();
        applyStimulus(0, '0, 0, 0, '0, '0, 1, 0, 0, '0);
        tick();
        applyStimulus(0, '0, 0, 0, '0, '0, 0, 1, 1, 64'hDEAD_BEEF);
        tick();
        quiet();
        #1;
        checkOutput("t2_dAckValid", dcache_resp_valid, 1);
        checkOutput("t2_dAckData", dcache_resp_block_data, 0);
        checkOutput("t2_iRespValid", icache_resp_valid, 0);

        // Both caches requesting continuously with a zero-wait memory.
        doReset();
        grantCount = 0;
        grantLog   = '0;
        logEnable  = 1'b1;
        for (int c = 0; c < 200 && grantCount < 10; c++) begin
            applyStimulus(1, AW'($urandom), 1, 1'($urandom_range(0, 1)), AW'($urandom),
                          {$urandom, $urandom}, 1, (mBusy && mIssued), mCache,
                          {$urandom, $urandom});
            tick();
        end
        logEnable = 1'b0;
        checkOutput("t3_grantCount", 64'(grantCount), 10);
        checkOutput("t3_grantSeq", grantLog, expSeq);

        // Response tagged for the wrong cache while waiting on the icache.
        doReset();
        applyStimulus(1, 32'h100, 0, 0, '0, '0, 0, 0, 0, '0);
        tick();
        applyStimulus(0, '0, 0, 0, '0, '0, 1, 0, 0, '0);
        tick();
        applyStimulus(0, '0, 0, 0, '0, '0, 0, 1, 1, 64'h123);
        tick();
        quiet();
        #1;
        checkOutput("t4_noIResp", icache_resp_valid, 0);
        checkOutput("t4_noDResp", dcache_resp_valid, 0);
        checkOutput("t4_err", arb_err, 1);
        checkOutput("t4_stillBusy", arb_busy, 1);
        tick();
        applyStimulus(0, '0, 0, 0, '0, '0, 0, 1, 0, 64'h5555);
        tick();
        quiet();
        #1;
        checkOutput("t4_iRespValid", icache_resp_valid, 1);
        checkOutput("t4_iRespData", icache_resp_block_data, 64'h5555);
        checkOutput("t4_idle", arb_busy, 0);

        // Reset while waiting, then the late response arrives in IDLE.
        tick();
        applyStimulus(0, '0, 1, 0, 32'h200, 64'h77, 0, 0, 0, '0);
        tick();
        applyStimulus(0, '0, 0, 0, '0, '0, 1, 0, 0, '0);
        tick();
        rst = 1'b1;
        quiet();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("t5_busy", arb_busy, 0);
        checkOutput("t5_memValid", mem_req_valid, 0);
        checkOutput("t5_memAddr", mem_req_block_addr, 0);
        checkOutput("t5_errCleared", arb_err, 0);
        applyStimulus(0, '0, 0, 0, '0, '0, 0, 1, 1, 64'h99);
        tick();
        quiet();
        #1;
        checkOutput("t5_noDResp", dcache_resp_valid, 0);
        checkOutput("t5_err", arb_err, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("t6_errSticky", arb_err, 1);
        end
        doReset();
        #1;
        checkOutput("t6_errClearedByRst", arb_err, 0);

        // Randomized traffic with stalls, wrong-owner and spurious responses
        // and occasional resets.
        for (int c = 0; c < 800; c++) begin
            tick();
            rst                   = ($urandom_range(0, 59) == 0);
            icache_req_valid      = 1'($urandom_range(0, 1));
            icache_req_block_addr = AW'($urandom);
            dcache_req_valid      = 1'($urandom_range(0, 1));
            dcache_req_type       = 1'($urandom_range(0, 1));
            dcache_req_block_addr = AW'($urandom);
            dcache_req_block_data = {$urandom, $urandom};
            mem_req_ready         = ($urandom_range(0, 2) != 0);
            mem_resp_block_data   = {$urandom, $urandom};
            if (mBusy && mIssued && ($urandom_range(0, 1) == 1)) begin
                mem_resp_valid      = 1'b1;
                mem_resp_cache_type = ($urandom_range(0, 7) == 0) ? !mCache : mCache;
            end else if ($urandom_range(0, 31) == 0) begin
                mem_resp_valid      = 1'b1;
                mem_resp_cache_type = 1'($urandom_range(0, 1));
            end else begin
                mem_resp_valid      = 1'b0;
                mem_resp_cache_type = 1'b0;
            end
        end
        tick();
        rst = 1'b0;
        quiet();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
